// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder: operands and mode in,
// status and registered result out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, sub, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, sub, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop,
// one bit per clock LSB first, result published only on completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             overflow_reg;
    logic             done_reg;

    logic s_bit;
    logic c_next;

    // The single full-adder cell; subtraction already folded into b_reg and carry.
    assign s_bit  = a_reg[0] ^ b_reg[0] ^ carry;
    assign c_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);

    // NOTE: every register here is sequential state, so it is written with <=
    // only; blocking assignments would let later statements see updated values.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all state, including the operand and working registers, is
        // cleared on reset so an aborted operation leaves nothing behind.
        if (rst) begin
            state        <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            res_reg      <= '0;
            carry        <= 1'b0;
            bit_cnt      <= '0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b ^ {WIDTH{bus.sub}};
                        carry   <= bus.cin ^ bus.sub;
                        res_reg <= '0;
                        bit_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    carry   <= c_next;
                    res_reg <= {s_bit, res_reg[WIDTH-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        // carry holds the carry into the MSB, c_next the carry out of it.
                        sum_reg      <= {s_bit, res_reg[WIDTH-1:1]};
                        cout_reg     <= c_next;
                        overflow_reg <= carry ^ c_next;
                        done_reg     <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = done_reg;
    assign bus.sum      = sum_reg;
    assign bus.cout     = cout_reg;
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8 with hand-computed results.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] held_sum;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation from a start pulse; poke >= 0 re-pulses start with other
    // operands on that busy cycle (0 = first busy cycle).
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tsub, input logic tcin, input int poke,
                          input logic [7:0] esum, input logic ecout, input logic eov);
        int cycles;
        @(negedge clk);
        bus.a = ta; bus.b = tb_v; bus.sub = tsub; bus.cin = tcin; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 20) begin
            check({tag, " sum_hold"}, {24'd0, bus.sum}, {24'd0, held_sum});
            check({tag, " no_done"}, {31'd0, bus.done}, 32'd0);
            if (cycles == poke) begin
                bus.a = 8'h01; bus.b = 8'h01; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, " busy_cycles"}, cycles, WIDTH);
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " sum"}, {24'd0, bus.sum}, {24'd0, esum});
        check({tag, " cout"}, {31'd0, bus.cout}, {31'd0, ecout});
        check({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, eov});
        held_sum = esum;
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " sum_after"}, {24'd0, bus.sum}, {24'd0, esum});
    endtask

    initial begin
        int last;
        int n_done;
        int guard;
        checks = 0;
        errors = 0;
        held_sum = 8'h00;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset sum", {24'd0, bus.sum}, 32'd0);
        check("reset cout", {31'd0, bus.cout}, 32'd0);
        check("reset overflow", {31'd0, bus.overflow}, 32'd0);

        // start during reset must be ignored
        bus.a = 8'h5A; bus.b = 8'h3C; bus.start = 1'b1;
        repeat (2) @(negedge clk);
        check("start_in_reset busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, -1, 8'h96, 1'b0, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, -1, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_00_cin", 8'h7F, 8'h00, 1'b0, 1'b1, -1, 8'h80, 1'b0, 1'b1);
        run_op("ignore_start", 8'h5A, 8'h3C, 1'b0, 1'b0, 2, 8'h96, 1'b0, 1'b1);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0, -1, 8'hF0, 1'b0, 1'b0);
        run_op("sub_20_10_bin", 8'h20, 8'h10, 1'b1, 1'b1, -1, 8'h0F, 1'b1, 1'b0);

        // Reset on the fourth busy cycle aborts the operation.
        @(negedge clk);
        bus.a = 8'h33; bus.b = 8'h44; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy_before", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort sum", {24'd0, bus.sum}, 32'd0);
        check("abort cout", {31'd0, bus.cout}, 32'd0);
        check("abort overflow", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        held_sum = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort no_done", {31'd0, bus.done}, 32'd0);
        end
        run_op("after_abort", 8'h5A, 8'h3C, 1'b0, 1'b0, -1, 8'h96, 1'b0, 1'b1);

        // start held high: a done pulse every WIDTH+1 cycles.
        @(negedge clk);
        bus.a = 8'h5A; bus.b = 8'h3C; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        last = -1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                check("stream sum", {24'd0, bus.sum}, 32'h96);
                if (last >= 0) check("stream period", i - last, WIDTH + 1);
                last = i;
            end
        end
        bus.start = 1'b0;
        check("stream done_count", n_done, 3);
        guard = 0;
        while ((bus.busy || bus.done) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("stream drained", {31'd0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an operation; sampled only when idle.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 sub  input  1  mode, captured on accepted start: 0 = A+B+cin, 1 = A-B-cin (cin acts as borrow-in).
REQ-008 cin  input  1  carry-in (add) or borrow-in (sub), captured on accepted start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking a new valid result.
REQ-011 sum  output  WIDTH  result, registered.
REQ-012 cout  output  1  carry-out; in sub mode 1 = no borrow, 0 = borrow.
REQ-013 overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-014 The block shall be a bit-serial adder: one full-adder cell plus a carry flip-flop, processing one bit per cycle, LSB first.
REQ-015 FSM states shall be IDLE and RUN; busy = (state == RUN).
REQ-016 IDLE -> RUN on a rising edge with start=1; a, b, sub and cin are captured at that edge.
REQ-017 On capture, the B operand register shall hold b XOR {WIDTH{sub}}, and the carry flip-flop shall load cin XOR sub.
REQ-018 In RUN, each edge shall compute bit i: s = a_i ^ b'_i ^ c and c' = majority(a_i, b'_i, c); it then shifts operands right and shifts s into the MSB of a working result register.
REQ-019 A bit counter of width clog2(WIDTH) shall count 0..WIDTH-1; it shall not wrap within an operation.
REQ-020 RUN -> IDLE on the edge that processes bit WIDTH-1; busy is therefore high for exactly WIDTH cycles after the accepting edge.
REQ-021 On that same edge, sum shall load the working result and cout the final carry; overflow shall load (carry into MSB) XOR (carry out of MSB), and done shall be 1 for exactly one cycle.
REQ-022 sum, cout and overflow shall hold their values from completion until the next completion; they shall never show partial results while busy.
REQ-023 start while busy=1 shall be ignored, with no effect on the operation in progress; operand inputs may change freely while busy.
REQ-024 start high in the cycle done is high shall be accepted, since busy=0 then; back-to-back operations thus have a period of WIDTH+1 cycles.
REQ-025 start held continuously high shall start a new operation every WIDTH+1 cycles.
REQ-026 The block shall contain no combinational path from any input to any output.

Reset
REQ-027 rst=1 shall immediately, without waiting for clk, force state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, and clear the counter, carry and operand registers.
REQ-028 Reset asserted mid-operation shall abort it; no done pulse shall follow, and the first edge after rst deasserts may accept start.
REQ-029 While rst=1, start shall be ignored.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x3C, sub=0, cin=0, start pulse -> busy 8 cycles; then done=1 for 1 cycle, sum=0x96, cout=0, overflow=1.
REQ-031 a=0xFF, b=0x01, sub=0, cin=0 -> sum=0x00, cout=1, overflow=0; then a=0x7F, b=0x00, cin=1 -> sum=0x80, overflow=1.
REQ-032 a=0x10, b=0x20, sub=1, cin=0 -> sum=0xF0, cout=0 (borrow), overflow=0; then a=0x20, b=0x10, cin=1 -> sum=0x0F, cout=1.
REQ-033 start re-pulsed with a=0x01, b=0x01 on cycle 3 of an operation -> ignored; the original result appears on schedule and busy does not extend.
REQ-034 rst asserted on cycle 4 of an operation -> busy, done, sum, cout and overflow are 0 immediately; no done follows; the next start completes correctly.
REQ-035 start held high for 30 cycles with constant operands -> done pulses exactly every 9 cycles with an identical sum each time.
